// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_arbiter_if : port A, port B and memory-side signal bundle     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface dmem_arbiter_if #(
    parameter int AW = 30
);
    logic          a_req;
    logic          a_lock;
    logic          a_we;
    logic [3:0]    a_be;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wd;
    logic          a_gnt;
    logic          a_rvalid;
    logic [31:0]   a_rd;

    logic          b_req;
    logic          b_lock;
    logic          b_we;
    logic [3:0]    b_be;
    logic [AW-1:0] b_addr;
    logic [31:0]   b_wd;
    logic          b_gnt;
    logic          b_rvalid;
    logic [31:0]   b_rd;

    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;

    modport slave (
        input  a_req, a_lock, a_we, a_be, a_addr, a_wd,
        input  b_req, b_lock, b_we, b_be, b_addr, b_wd,
        input  mem_rd,
        output a_gnt, a_rvalid, a_rd,
        output b_gnt, b_rvalid, b_rd,
        output mem_we, mem_be, mem_addr, mem_wd
    );

    modport master (
        output a_req, a_lock, a_we, a_be, a_addr, a_wd,
        output b_req, b_lock, b_we, b_be, b_addr, b_wd,
        output mem_rd,
        input  a_gnt, a_rvalid, a_rd,
        input  b_gnt, b_rvalid, b_rd,
        input  mem_we, mem_be, mem_addr, mem_wd
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_arbiter : round-robin CPU/DMA arbiter for the data memory     |
// | with bus lock and lock watchdog; DMEM_ARB_STATS_EN adds counters.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module dmem_arbiter #(
    parameter int AW       = 30,
    parameter int MAX_LOCK = 16
`ifdef DMEM_ARB_STATS_EN
   ,parameter int CW       = 16
`endif
) (
    input  wire           clk,
    input  wire           rst_n,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
   ,input  wire           stats_clr,
    output logic [CW-1:0] a_gcnt,
    output logic [CW-1:0] b_gcnt,
    output logic [CW-1:0] cont_cnt
`endif
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_lock_a = 2'd1;
    localparam logic [1:0] c_st_lock_b = 2'd2;
    localparam logic [8:0] c_max_lock  = 9'(MAX_LOCK);

    logic [1:0]    r_state;
    logic          r_last;      // 1: port B was granted last
    logic [7:0]    r_lcnt;
    logic          r_rpend;
    logic          r_rsel;

    logic          w_a_elig;
    logic          w_b_elig;
    logic          w_a_gnt;
    logic          w_b_gnt;
    logic          w_gnt;
    logic          w_g_lock;
    logic          w_g_we;
    logic [AW-1:0] w_addr;
    logic [8:0]    w_lcnt_inc;

    always_comb begin
        w_a_elig   = rst_n && bus.a_req && (r_state != c_st_lock_b);
        w_b_elig   = rst_n && bus.b_req && (r_state != c_st_lock_a);
        w_a_gnt    = w_a_elig && (!w_b_elig || r_last);
        w_b_gnt    = w_b_elig && !w_a_gnt;
        w_gnt      = w_a_gnt || w_b_gnt;
        w_g_lock   = w_b_gnt ? bus.b_lock : bus.a_lock;
        w_g_we     = w_b_gnt ? bus.b_we   : bus.a_we;
        w_addr     = w_b_gnt ? bus.b_addr : bus.a_addr;
        w_lcnt_inc = {1'b0, r_lcnt} + 9'd1;
    end

    // Idle cycles leave port A's fields on the memory bus with WE low.
    assign bus.a_gnt    = w_a_gnt;
    assign bus.b_gnt    = w_b_gnt;
    assign bus.mem_we   = w_gnt && w_g_we;
    assign bus.mem_be   = w_b_gnt ? bus.b_be : bus.a_be;
    assign bus.mem_addr = w_addr;
    assign bus.mem_wd   = w_b_gnt ? bus.b_wd : bus.a_wd;

    // Gating with rst_n drops a response already in flight when reset hits.
    assign bus.a_rvalid = rst_n && r_rpend && !r_rsel;
    assign bus.b_rvalid = rst_n && r_rpend &&  r_rsel;
    assign bus.a_rd     = bus.mem_rd;
    assign bus.b_rd     = bus.mem_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_last  <= 1'b1;
            r_lcnt  <= 8'd0;
            r_rpend <= 1'b0;
            r_rsel  <= 1'b0;
        end else begin
            r_rpend <= w_gnt && !w_g_we;
            r_rsel  <= w_b_gnt;
            if (w_gnt) begin
                r_last <= w_b_gnt;
                if (w_g_lock && (w_lcnt_inc < c_max_lock)) begin
                    r_state <= w_b_gnt ? c_st_lock_b : c_st_lock_a;
                    r_lcnt  <= w_lcnt_inc[7:0];
                end else begin
                    // Plain unlocked access or watchdog expiry both free the bus.
                    r_state <= c_st_idle;
                    r_lcnt  <= 8'd0;
                end
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    localparam logic [CW-1:0] c_cnt_max = '1;

    logic [CW-1:0] r_a_gcnt;
    logic [CW-1:0] r_b_gcnt;
    logic [CW-1:0] r_cont_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            r_a_gcnt   <= '0;
            r_b_gcnt   <= '0;
            r_cont_cnt <= '0;
        end else begin
            if (w_a_gnt && (r_a_gcnt != c_cnt_max))
                r_a_gcnt <= r_a_gcnt + CW'(1);
            if (w_b_gnt && (r_b_gcnt != c_cnt_max))
                r_b_gcnt <= r_b_gcnt + CW'(1);
            if (bus.a_req && bus.b_req && (r_cont_cnt != c_cnt_max))
                r_cont_cnt <= r_cont_cnt + CW'(1);
        end
    end

    assign a_gcnt   = r_a_gcnt;
    assign b_gcnt   = r_b_gcnt;
    assign cont_cnt = r_cont_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single-port, byte-enabled data memory between the CPU data port (port A) and the DMA/sensor-bus master (port B). Round-robin on contention, with optional bus lock for atomic multi-word sequences and a lock watchdog. Accepted requests drive the memory combinationally; read data returns one cycle later, matching the memory's registered read.

Parameters:
AW, 30, word-address width on both ports and the memory side
MAX_LOCK, 16, maximum consecutive locked grants before lock is forcibly released (range 1..255)
CW, 16, width of optional statistics counters

Ports:
CLK  in  1  clock, all state on posedge
RST_N  in  1  synchronous reset, active-low
A_REQ  in  1  port A access request
A_LOCK  in  1  port A requests to keep ownership after this access
A_WE  in  1  port A write enable
A_BE  in  4  port A byte enables
A_ADDR  in  AW  port A word address
A_WD  in  32  port A write data
A_GNT  out  1  port A access accepted this cycle (combinational)
A_RVALID  out  1  port A read data valid
A_RD  out  32  port A read data
B_REQ, B_LOCK, B_WE, B_BE, B_ADDR, B_WD, B_GNT, B_RVALID, B_RD  same as port A, for port B
MEM_WE  out  1  to memory WE
MEM_BE  out  4  to memory BE
MEM_ADDR  out  AW  to memory ADDR
MEM_WD  out  32  to memory WD
MEM_RD  in  32  from memory RD, valid the cycle after address presented

Behaviour:
- State: OWNER FSM {IDLE, LOCK_A, LOCK_B}; LAST (last granted port, 1 bit); LCNT (8-bit locked-grant counter); RSEL/RPEND pipeline registers.
- Reset (RST_N=0 at posedge): FSM=IDLE, LAST=B (so A wins the first tie), LCNT=0, RPEND=0, A_RVALID=B_RVALID=0. While RST_N=0, A_GNT=B_GNT=0 and MEM_WE=0 combinationally. In-flight read responses are discarded.
- Grant in IDLE: only one REQ -> grant it. Both -> grant the port != LAST. Neither -> no grant; MEM_WE=0, MEM_ADDR/BE/WD hold port A's values.
- Grant in LOCK_x: only port x may be granted; the other port's REQ waits (GNT=0) regardless of LAST.
- At most one GNT per cycle. The granted port's WE/BE/ADDR/WD are muxed to MEM_* in the same cycle. A write completes on the GNT cycle.
- On a grant, LAST <= granted port.
- FSM transitions, evaluated on a grant to port x:
  - LOCK=1 and LCNT+1 < MAX_LOCK -> LOCK_x, LCNT <= LCNT+1.
  - LOCK=0 -> IDLE, LCNT <= 0.
  - LOCK=1 and LCNT+1 == MAX_LOCK (watchdog) -> IDLE, LCNT <= 0, LAST=x, so the other port wins the next tie.
- In LOCK_x with no request from x: state and LCNT hold. A held lock blocks the other port until x issues an access with LOCK=0 or the watchdog fires.
- Read response:
  - A granted read (WE=0) sets RPEND=1 and RSEL=port for the next cycle.
  - That cycle, the selected port's RVALID=1 and xRD=MEM_RD. The other port's RVALID=0 and its RD is don't-care.
  - Back-to-back reads give one RVALID per cycle, in grant order. Writes produce no RVALID.
- RVALID is a 1-cycle pulse with no backpressure; requesters must capture it.
- REQ may be dropped without a grant; there is no commitment to hold REQ.

Optional Feature:
Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs A_GCNT, B_GCNT, CONT_CNT (each CW bits).
  - Per-port grant counts and count of cycles with both REQ high.
  - All three saturate at all-ones and reset to 0.
  - Input STATS_CLR (1 bit) zeroes all three synchronously; it has priority over increment in the same cycle.
- Not defined: these ports and registers do not exist; arbitration behaviour is identical.

Test Plan:
- Reset release with A_REQ=B_REQ=1, both reads, held 4 cycles -> grants A,B,A,B; A_RVALID in cycles 2 and 4, B_RVALID in cycles 3 and 5; RD matches preloaded words.
- A write ADDR=5, BE=4'b0011, WD=32'hDEADBEEF over existing 32'h11223344, then A read ADDR=5 -> A_RD=32'h1122BEEF one cycle after the read grant.
- A_LOCK=1 for 3 accesses, then LOCK=0, with B_REQ=1 throughout -> A granted 4 consecutive times, B_GNT=0 until the cycle after A's unlocked access, then B granted.
- MAX_LOCK=4, A_REQ=A_LOCK=1 continuously, B_REQ=1 -> A granted 4 times, watchdog releases, B granted on the 5th grant cycle, then A re-locks.
- RST_N=0 asserted the cycle after a B read grant -> no B_RVALID; after release FSM=IDLE and the first tie goes to A.
- DMEM_ARB_STATS_EN: 10 contention cycles, then STATS_CLR pulse -> A_GCNT=5, B_GCNT=5, CONT_CNT=10 before the pulse, all 0 after; CW=4 saturation check at 15.
